hero_ctrl: RTL and testbench
============================

HERO_CTRL -- requirements
Module: hero_ctrl

Interface
REQ-001 Parameter ANIM_FRAMES, default 15, frame ticks per idle-animation toggle; legal range 1-255.
REQ-002 Parameter HOLD_FRAMES, default 8, frame ticks the move pose is held after acknowledge; legal range 1-255.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 frame_tick  input  1  one-cycle pulse per video frame.
REQ-006 key_up, key_down, key_left, key_right  input  1 each  direction keys, level, synchronous to clk.
REQ-007 move_ack  input  1  game logic accepts the pending move.
REQ-008 move_req  output  1  move pending; held until acknowledged.
REQ-009 dir  output  2  direction select: 00 up, 01 down, 10 left, 11 right.
REQ-010 pressed  output  1  selects the directional pose instead of the idle pose.
REQ-011 anim  output  1  idle-animation frame select: 1 = frame A, 0 = frame B.

Function
REQ-012 FSM states: IDLE, PRESS, HOLD; all outputs registered.
REQ-013 Edge detect: key history register per key; rise = key & ~history; history updates every cycle in every state.
REQ-014 IDLE, any rise -> PRESS next cycle; dir loads the winner, move_req=1, pressed=1 (one-cycle latency).
REQ-015 Simultaneous rises resolve by fixed priority: up > down > left > right.
REQ-016 Rises while in PRESS or HOLD are discarded, not queued.
REQ-017 PRESS: move_req, dir and pressed stay stable until move_ack=1 is sampled.
REQ-018 PRESS with move_ack=1 -> HOLD next cycle; move_req=0; hold counter=0.
REQ-019 move_ack outside PRESS is ignored.
REQ-020 Hold counter (8 bit) increments on each frame_tick in HOLD.
REQ-021 HOLD exits to IDLE the cycle after a frame_tick sampled with counter == HOLD_FRAMES-1.
REQ-022 On the HOLD exit, pressed=0; dir keeps its last value.
REQ-023 Anim counter (8 bit) counts frame_tick only in IDLE.
REQ-024 When a frame_tick arrives with the anim counter == ANIM_FRAMES-1, anim toggles and the counter wraps to 0.
REQ-025 Anim counter clears to 0 on entry to PRESS; anim holds its value through PRESS and HOLD.
REQ-026 A frame_tick in the same cycle as a rise in IDLE: the transition to PRESS wins and the anim counter clears (no toggle).
REQ-027 A frame_tick in the same cycle as move_ack in PRESS does not count toward HOLD.

Reset
REQ-028 rst=1 forces on the next edge: state IDLE, move_req=0, dir=00, pressed=0, anim=1, both counters 0, key history 0000.
REQ-029 rst has priority over every other input, including mid-PRESS and mid-HOLD; a pending move is dropped without acknowledge.
REQ-030 A key held through reset is seen as a rise in the first cycle after rst deasserts.

Verification
REQ-031 Reset release, then key_left pulse for 1 cycle -> next cycle move_req=1, dir=10, pressed=1.
REQ-032 key_up and key_right rise in the same cycle -> dir=00; a later key_down rise during PRESS is ignored, dir stays 00.
REQ-033 HOLD_FRAMES=8, move_ack after 5 cycles -> move_req falls next cycle; pressed falls exactly 1 cycle after the 8th subsequent frame_tick.
REQ-034 ANIM_FRAMES=15, idle, 45 frame_ticks -> anim toggles 3 times (1->0->1->0), each toggle 1 cycle after ticks 15, 30 and 45.
REQ-035 rst pulsed during HOLD with dir=11 -> next cycle pressed=0, dir=00, anim=1; key_right still held -> rise, PRESS with dir=11 one cycle after rst release.
REQ-036 move_ack=1 while in IDLE, and frame_tick coincident with a rise -> no state change from the ack; anim unchanged and anim counter 0.

Source files
------------

// File: rtl/hero_ctrl.sv
// hero_ctrl -- sprite pose controller for the player character.
//
// Turns direction-key presses into a single pending move request for the game
// logic. Once the game acknowledges the move, the directional pose is held for a
// fixed number of video frames. While the hero is idle, a two-frame idle animation
// alternates at a programmable frame rate.
//
// Parameters
//   ANIM_FRAMES  frame ticks per idle-animation toggle (1..255)
//   HOLD_FRAMES  frame ticks the move pose is held after acknowledge (1..255)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   frame_tick   in   one-cycle pulse per video frame
//   key_up/down/left/right
//                in   direction keys, level, synchronous to clk
//   move_ack     in   game logic accepts the pending move
//   move_req     out  move pending, held until acknowledged
//   dir          out  00 up, 01 down, 10 left, 11 right
//   pressed      out  1 = directional pose, 0 = idle pose
//   anim         out  idle-animation frame select, 1 = frame A, 0 = frame B
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no move pending; idle animation runs; watching for a key rise
// PRESS   | move_req raised, dir latched; waiting for move_ack
// HOLD    | move accepted; directional pose held for HOLD_FRAMES ticks

module hero_ctrl #(
  parameter int ANIM_FRAMES = 15,
  parameter int HOLD_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       move_ack,
  output logic       move_req,
  output logic [1:0] dir,
  output logic       pressed,
  output logic       anim
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t     state, state_n;
  logic [3:0] keys;
  logic [3:0] key_hist;
  logic [3:0] key_rise;
  logic [1:0] win_dir;
  logic [7:0] anim_cnt, anim_cnt_n;
  logic [7:0] hold_cnt, hold_cnt_n;
  logic       move_req_n;
  logic [1:0] dir_n;
  logic       pressed_n;
  logic       anim_n;

  // Bit index matches the dir encoding: up=0, down=1, left=2, right=3.
  assign keys     = {key_right, key_left, key_down, key_up};
  assign key_rise = keys & ~key_hist;

  // Fixed priority among simultaneous rises: up > down > left > right.
  always_comb begin
    win_dir = 2'b11;
    if (key_rise[0]) begin
      win_dir = 2'b00;
    end else if (key_rise[1]) begin
      win_dir = 2'b01;
    end else if (key_rise[2]) begin
      win_dir = 2'b10;
    end
  end

  always_comb begin
    state_n    = state;
    move_req_n = move_req;
    dir_n      = dir;
    pressed_n  = pressed;
    anim_n     = anim;
    anim_cnt_n = anim_cnt;
    hold_cnt_n = hold_cnt;

    unique case (state)
      ST_IDLE: begin
        // A rise beats a coincident frame tick: no animation step that cycle.
        if (|key_rise) begin
          state_n    = ST_PRESS;
          dir_n      = win_dir;
          move_req_n = 1'b1;
          pressed_n  = 1'b1;
          anim_cnt_n = 8'd0;
        end else if (frame_tick) begin
          if (anim_cnt == ANIM_LAST) begin
            anim_n     = ~anim;
            anim_cnt_n = 8'd0;
          end else begin
            anim_cnt_n = anim_cnt + 8'd1;
          end
        end
      end

      ST_PRESS: begin
        // Key rises here are dropped; a tick alongside the ack is not counted.
        if (move_ack) begin
          state_n    = ST_HOLD;
          move_req_n = 1'b0;
          hold_cnt_n = 8'd0;
        end
      end

      ST_HOLD: begin
        if (frame_tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_n    = ST_IDLE;
            pressed_n  = 1'b0;
            hold_cnt_n = 8'd0;
          end else begin
            hold_cnt_n = hold_cnt + 8'd1;
          end
        end
      end

      default: begin
        state_n    = ST_IDLE;
        move_req_n = 1'b0;
        pressed_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      move_req <= 1'b0;
      dir      <= 2'b00;
      pressed  <= 1'b0;
      anim     <= 1'b1;
      anim_cnt <= 8'd0;
      hold_cnt <= 8'd0;
      // Cleared history makes a key held through reset register as a rise.
      key_hist <= 4'b0000;
    end else begin
      state    <= state_n;
      move_req <= move_req_n;
      dir      <= dir_n;
      pressed  <= pressed_n;
      anim     <= anim_n;
      anim_cnt <= anim_cnt_n;
      hold_cnt <= hold_cnt_n;
      key_hist <= keys;
    end
  end

endmodule

// File: tb/tb_hero_ctrl.sv
module tb_hero_ctrl;

  localparam int ANIM_FRAMES = 15;
  localparam int HOLD_FRAMES = 8;

  typedef struct packed {
    logic       move_req;
    logic [1:0] dir;
    logic       pressed;
    logic       anim;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       move_ack = 1'b0;
  logic       move_req;
  logic [1:0] dir;
  logic       pressed;
  logic       anim;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit started = 1'b0;

  exp_t q[$];

  // Reference model state, in terms of what the player sees.
  bit [3:0] m_prev_keys;
  bit       m_waiting_ack;
  bit       m_pose;
  bit [1:0] m_dir;
  bit       m_anim;
  int       m_idle_ticks;
  int       m_hold_left;

  always #5 clk = ~clk;

  hero_ctrl #(
    .ANIM_FRAMES(ANIM_FRAMES),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .move_ack  (move_ack),
    .move_req  (move_req),
    .dir       (dir),
    .pressed   (pressed),
    .anim      (anim)
  );

  // Model: evaluates the rules on the inputs seen at each rising edge and
  // queues the outputs the DUT must show after that edge.
  always @(posedge clk) begin : model
    bit [3:0] k;
    bit [3:0] rise;
    exp_t e;
    cyc++;
    k = {key_right, key_left, key_down, key_up};
    if (rst) begin
      started       = 1'b1;
      m_prev_keys   = 4'b0000;
      m_waiting_ack = 1'b0;
      m_pose        = 1'b0;
      m_dir         = 2'b00;
      m_anim        = 1'b1;
      m_idle_ticks  = 0;
      m_hold_left   = 0;
    end else if (started) begin
      rise = k & ~m_prev_keys;
      if (!m_pose) begin
        if (rise != 4'b0000) begin
          for (int i = 3; i >= 0; i--) begin
            if (rise[i]) m_dir = 2'(i);
          end
          m_waiting_ack = 1'b1;
          m_pose        = 1'b1;
          m_idle_ticks  = 0;
        end else if (frame_tick) begin
          m_idle_ticks++;
          if (m_idle_ticks == ANIM_FRAMES) begin
            m_anim       = ~m_anim;
            m_idle_ticks = 0;
          end
        end
      end else if (m_waiting_ack) begin
        if (move_ack) begin
          m_waiting_ack = 1'b0;
          m_hold_left   = HOLD_FRAMES;
        end
      end else begin
        if (frame_tick) begin
          m_hold_left--;
          if (m_hold_left == 0) m_pose = 1'b0;
        end
      end
      m_prev_keys = k;
    end
    if (started) begin
      e.move_req = m_waiting_ack;
      e.dir      = m_dir;
      e.pressed  = m_pose;
      e.anim     = m_anim;
      q.push_back(e);
    end
  end

  // Monitor: outputs are registered and valid every cycle once reset is seen.
  always @(posedge clk) begin : monitor
    exp_t e;
    exp_t a;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {move_req, dir, pressed, anim};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got req=%0b dir=%0d pressed=%0b anim=%0b want req=%0b dir=%0d pressed=%0b anim=%0b",
                 cyc, a.move_req, a.dir, a.pressed, a.anim,
                 e.move_req, e.dir, e.pressed, e.anim);
      end
    end
  end

  task automatic drive(input bit r, input bit t, input bit [3:0] k, input bit a);
    @(negedge clk);
    rst        = r;
    frame_tick = t;
    {key_right, key_left, key_down, key_up} = k;
    move_ack   = a;
  endtask

  task automatic idle(input int n, input bit [3:0] k);
    repeat (n) drive(1'b0, 1'b0, k, 1'b0);
  endtask

  task automatic ticks(input int n, input int gap, input bit [3:0] k);
    repeat (n) begin
      drive(1'b0, 1'b1, k, 1'b0);
      idle(gap, k);
    end
  endtask

  initial begin : timeout
    #400000;
    $display("FAIL timeout cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit [3:0] kv;
    repeat (3) drive(1'b1, 1'b0, 4'b0000, 1'b0);

    // Left pulse one cycle after reset release; ack; hold through 8 ticks.
    drive(1'b0, 1'b0, 4'b0100, 1'b0);
    idle(4, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000, 1'b1);
    ticks(8, 2, 4'b0000);
    idle(3, 4'b0000);

    // Up and right together; down rises during PRESS and must be ignored.
    drive(1'b0, 1'b0, 4'b1001, 1'b0);
    idle(2, 4'b1001);
    drive(1'b0, 1'b0, 4'b1011, 1'b0);
    idle(2, 4'b1011);
    drive(1'b0, 1'b0, 4'b1011, 1'b1);
    ticks(8, 1, 4'b1011);
    idle(2, 4'b0000);

    // Ack after 5 cycles; pose released one cycle after the 8th tick.
    drive(1'b0, 1'b0, 4'b0010, 1'b0);
    idle(4, 4'b0000);
    drive(1'b0, 1'b0, 4'b0000, 1'b1);
    ticks(8, 3, 4'b0000);
    idle(2, 4'b0000);

    // 45 idle ticks -> three animation toggles.
    ticks(45, 1, 4'b0000);
    idle(3, 4'b0000);

    // Reset during HOLD with right held; right re-detected after release.
    drive(1'b0, 1'b0, 4'b1000, 1'b0);
    idle(1, 4'b1000);
    drive(1'b0, 1'b0, 4'b1000, 1'b1);
    ticks(3, 1, 4'b1000);
    drive(1'b1, 1'b0, 4'b1000, 1'b0);
    drive(1'b0, 1'b0, 4'b1000, 1'b0);
    idle(2, 4'b1000);
    drive(1'b0, 1'b0, 4'b1000, 1'b1);
    ticks(8, 0, 4'b1000);
    idle(2, 4'b0000);

    // Ack in IDLE is ignored; tick coincident with a rise clears the count.
    drive(1'b0, 1'b0, 4'b0000, 1'b1);
    drive(1'b0, 1'b0, 4'b0000, 1'b1);
    ticks(5, 1, 4'b0000);
    drive(1'b0, 1'b1, 4'b0001, 1'b0);
    idle(2, 4'b0000);
    drive(1'b0, 1'b1, 4'b0000, 1'b1);
    ticks(8, 1, 4'b0000);
    ticks(16, 0, 4'b0000);
    idle(2, 4'b0000);

    // Random traffic.
    kv = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) kv[b] = ~kv[b];
      end
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) == 0),
            kv,
            ($urandom_range(0, 2) == 0));
    end

    idle(3, 4'b0000);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
